// File: rtl/branch_predict_unit.sv
// Conditional branch resolution from ALU flags, with a PC-indexed table of 2-bit
// saturating counters for fetch-time prediction and saturating performance counters.
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  INIT_STATE  = 2'b01,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pc_if,
  output logic                  pred_taken_if,
  input  logic                  branch_ex,
  input  logic                  stall_ex,
  input  logic [2:0]            funct3_ex,
  input  logic                  cf,
  input  logic                  zf,
  input  logic                  vf,
  input  logic                  sf,
  input  logic [PC_WIDTH-1:0]   pc_ex,
  input  logic                  pred_taken_ex,
  output logic                  branch_taken,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] perf_branches,
  output logic [STAT_WIDTH-1:0] perf_mispred
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]            bht_q [BHT_ENTRIES];
  logic [1:0]            bht_d [BHT_ENTRIES];
  logic [IDX_W-1:0]      idx_if;
  logic [IDX_W-1:0]      idx_ex;
  logic                  funct_ok;
  logic                  cond;
  logic                  vb;
  logic [1:0]            ctr;
  logic [1:0]            ctr_next;
  logic [STAT_WIDTH-1:0] perf_branches_q, perf_branches_d;
  logic [STAT_WIDTH-1:0] perf_mispred_q, perf_mispred_d;
  logic                  unused_pc;

  // Word-aligned PCs: the two byte-offset bits carry no information.
  assign idx_if = pc_if[IDX_W+1:2];
  assign idx_ex = pc_ex[IDX_W+1:2];
  assign unused_pc = ^{pc_if[PC_WIDTH-1:IDX_W+2], pc_if[1:0],
                       pc_ex[PC_WIDTH-1:IDX_W+2], pc_ex[1:0]};

  // No bypass: a same-cycle update to idx_if shows up only from the next cycle.
  assign pred_taken_if = bht_q[idx_if][1];

  // cf is the subtract carry, so cf = 1 means rs1 >= rs2 unsigned.
  always_comb begin
    funct_ok = 1'b1;
    cond     = 1'b0;
    case (funct3_ex)
      3'b000:  cond = zf;
      3'b001:  cond = ~zf;
      3'b100:  cond = sf ^ vf;
      3'b101:  cond = ~(sf ^ vf);
      3'b110:  cond = ~cf;
      3'b111:  cond = cf;
      default: funct_ok = 1'b0;
    endcase
  end

  assign vb           = branch_ex & ~stall_ex & funct_ok;
  assign branch_taken = vb & cond;
  assign mispredict   = vb & (branch_taken != pred_taken_ex);

  always_comb begin
    ctr = bht_q[idx_ex];
    if (branch_taken) begin
      ctr_next = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end else begin
      ctr_next = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (vb) begin
      bht_d[idx_ex] = ctr_next;
    end
  end

  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_mispred_d  = perf_mispred_q;
    if (vb && (perf_branches_q != '1)) begin
      perf_branches_d = perf_branches_q + STAT_WIDTH'(1);
    end
    if (mispredict && (perf_mispred_q != '1)) begin
      perf_mispred_d = perf_mispred_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= INIT_STATE;
      end
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      bht_q           <= bht_d;
      perf_branches_q <= perf_branches_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_mispred  = perf_mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit: default instance plus a 4-bit
// statistics instance sharing the same stimulus to exercise counter saturation.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic        branch_ex;
  logic        stall_ex;
  logic [2:0]  funct3_ex;
  logic        cf, zf, vf, sf;
  logic [31:0] pc_ex;
  logic        pred_taken_ex;
  logic        branch_taken;
  logic        mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  logic        pred4, taken4, mp4;
  logic [3:0]  pb4, pm4;

  int checks   = 0;
  int failures = 0;
  int exp_br   = 0;
  int exp_mis  = 0;

  branch_predict_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_if         (pc_if),
    .pred_taken_if (pred_taken_if),
    .branch_ex     (branch_ex),
    .stall_ex      (stall_ex),
    .funct3_ex     (funct3_ex),
    .cf            (cf),
    .zf            (zf),
    .vf            (vf),
    .sf            (sf),
    .pc_ex         (pc_ex),
    .pred_taken_ex (pred_taken_ex),
    .branch_taken  (branch_taken),
    .mispredict    (mispredict),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  branch_predict_unit #(.STAT_WIDTH(4)) u_dut4 (
    .clk           (clk),
    .rst           (rst),
    .pc_if         (pc_if),
    .pred_taken_if (pred4),
    .branch_ex     (branch_ex),
    .stall_ex      (stall_ex),
    .funct3_ex     (funct3_ex),
    .cf            (cf),
    .zf            (zf),
    .vf            (vf),
    .sf            (sf),
    .pc_ex         (pc_ex),
    .pred_taken_ex (pred_taken_ex),
    .branch_taken  (taken4),
    .mispredict    (mp4),
    .perf_branches (pb4),
    .perf_mispred  (pm4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_perf(input string tag);
    check({tag, "/branches"}, perf_branches, 32'(exp_br));
    check({tag, "/mispred"}, perf_mispred, 32'(exp_mis));
  endtask

  // Drive one valid branch, check the EX outputs and the fetch prediction in that
  // cycle, then let the update edge pass.
  task automatic br(input string tag, input logic [2:0] f3, input logic c, input logic z,
                    input logic v, input logic s, input logic [31:0] pc, input logic pred,
                    input logic exp_t, input logic exp_mp, input logic exp_pif);
    funct3_ex = f3; cf = c; zf = z; vf = v; sf = s;
    pc_ex = pc; pred_taken_ex = pred; branch_ex = 1'b1; stall_ex = 1'b0;
    #1;
    check({tag, "/taken"}, 32'(branch_taken), 32'(exp_t));
    check({tag, "/mispredict"}, 32'(mispredict), 32'(exp_mp));
    check({tag, "/pred_if"}, 32'(pred_taken_if), 32'(exp_pif));
    @(posedge clk);
    #1;
    branch_ex = 1'b0;
    exp_br++;
    if (exp_mp) exp_mis++;
    #1;
  endtask

  // Branch that must not count or update (bad funct3 or stalled).
  task automatic guard(input string tag, input logic [2:0] f3, input logic stall,
                       input logic [31:0] pc, input logic pred);
    funct3_ex = f3; cf = 1'b1; zf = 1'b1; vf = 1'b0; sf = 1'b0;
    pc_ex = pc; pred_taken_ex = pred; branch_ex = 1'b1; stall_ex = stall;
    pc_if = pc;
    #1;
    check({tag, "/taken"}, 32'(branch_taken), 32'd0);
    check({tag, "/mispredict"}, 32'(mispredict), 32'd0);
    @(posedge clk);
    #1;
    branch_ex = 1'b0;
    stall_ex  = 1'b0;
    #1;
    check({tag, "/pred_if"}, 32'(pred_taken_if), 32'd0);
    check_perf(tag);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    exp_br  = 0;
    exp_mis = 0;
  endtask

  initial begin
    rst = 1'b0; pc_if = '0; branch_ex = 1'b0; stall_ex = 1'b0; funct3_ex = 3'b000;
    cf = 1'b0; zf = 1'b0; vf = 1'b0; sf = 1'b0; pc_ex = '0; pred_taken_ex = 1'b0;

    // Reset asserted away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_perf("rst_async");
    for (int i = 0; i < 64; i++) begin
      pc_if = 32'(i * 4);
      #1;
      check("rst_pred", 32'(pred_taken_if), 32'd0);
    end
    check("rst_taken", 32'(branch_taken), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // BEQ taken against a not-taken prediction.
    pc_if = 32'h100;
    br("beq", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0);
    check("beq/pred_after", 32'(pred_taken_if), 32'd1);
    check_perf("beq");

    // Saturation upward at 0x104, then walk back down.
    pc_if = 32'h104;
    br("bne_t0", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    br("bne_t1", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 1'b1);
    br("bne_t2", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 1'b1);
    br("bne_t3", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 1'b1);
    br("bne_n0", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1);
    check("bne/after_n0", 32'(pred_taken_if), 32'd1);
    br("bne_n1", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1);
    check("bne/after_n1", 32'(pred_taken_if), 32'd0);

    // Saturation downward at 0x108.
    pc_if = 32'h108;
    br("beq_n0", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    br("beq_n1", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    br("beq_n2", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    br("beq_t0", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 1'b1, 1'b1, 1'b0);
    br("beq_t1", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 1'b1, 1'b1, 1'b0);
    check("beq/after_t1", 32'(pred_taken_if), 32'd1);
    check_perf("sat");

    // Signed/unsigned conditions; fetch looks at an untouched entry.
    pc_if = 32'h3fc;
    br("blt_t",  3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    br("blt_n",  3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0);
    br("bge_t",  3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 1'b0);
    br("bge_n",  3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1c, 1'b1, 1'b0, 1'b1, 1'b0);
    br("bltu_n", 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0);
    br("bltu_t", 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 1'b1, 1'b0, 1'b0);
    br("bgeu_t", 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0);
    br("bgeu_n", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2c, 1'b1, 1'b0, 1'b1, 1'b0);
    br("bne_z",  3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 1'b0, 1'b1, 1'b0);
    check_perf("cond");

    // Reset between updates restores the table.
    pulse_rst();
    pc_if = 32'h100;
    #1;
    check("rst2/pred_100", 32'(pred_taken_if), 32'd0);
    pc_if = 32'h108;
    #1;
    check("rst2/pred_108", 32'(pred_taken_if), 32'd0);
    check_perf("rst2");

    // Same-cycle read and update of one entry: no bypass.
    pc_if = 32'h200;
    br("hazard", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
    check("hazard/next", 32'(pred_taken_if), 32'd1);
    pc_if = 32'h204;
    #1;
    check("hazard/neighbour", 32'(pred_taken_if), 32'd0);

    guard("f3_010", 3'b010, 1'b0, 32'h204, 1'b1);
    guard("f3_011", 3'b011, 1'b0, 32'h204, 1'b1);
    guard("stall", 3'b000, 1'b1, 32'h208, 1'b0);

    // Update edge while reset is held is discarded.
    pc_if = 32'h20c;
    funct3_ex = 3'b000; zf = 1'b1; pc_ex = 32'h20c; pred_taken_ex = 1'b0; branch_ex = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    branch_ex = 1'b0;
    exp_br = 0;
    exp_mis = 0;
    #1;
    check("rst_edge/pred", 32'(pred_taken_if), 32'd0);
    check_perf("rst_edge");

    // Twenty mispredictions: 32-bit counters reach 20, 4-bit ones stop at 15.
    pc_if = 32'h40;
    for (int i = 0; i < 20; i++) begin
      br("sat20", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b1, (i != 0));
    end
    check_perf("sat20");
    check("sat20/w4_branches", 32'(pb4), 32'd15);
    check("sat20/w4_mispred", 32'(pm4), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
